// File: rtl/adc_bringup_seq.sv
// Bring-up sequencer for the U72/U73 ADC pair: power-up wait, SPI register
// table load for both sides, sync pulse and lane-alignment wait with retries.
module adc_bringup_seq #(
   parameter int unsigned N_REGS    = 8,
   parameter int unsigned PWRUP_CYC = 1000,
   parameter int unsigned SYNC_LEN  = 4,
   parameter int unsigned ALIGN_TMO = 50000,
   parameter int unsigned ACK_TMO   = 4095,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic        clk10m,
   input  logic        sysrst_nr0,
   input  logic        start,
   output logic [3:0]  tbl_idx,
   input  logic [23:0] tbl_data,
   output logic        cfg_req,
   output logic        cfg_sel,
   output logic [7:0]  cfg_addr,
   output logic [15:0] cfg_data,
   input  logic        cfg_ack,
   output logic        adc_sync,
   input  logic        a_align_done,
   input  logic        b_align_done,
   input  logic        a_align_err,
   input  logic        b_align_err,
   output logic        busy,
   output logic        done,
   output logic        fail,
   output logic [1:0]  retry_cnt,
   output logic [3:0]  state_dbg
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_PWRUP = 4'd1,
      S_REQ   = 4'd2,
      S_WACK  = 4'd3,
      S_NEXT  = 4'd4,
      S_SYNC  = 4'd5,
      S_ALIGN = 4'd6,
      S_RETRY = 4'd7,
      S_DONE  = 4'd8,
      S_FAIL  = 4'd9
   } state_t;

   localparam logic [15:0] PWRUP_LAST = 16'(PWRUP_CYC - 1);
   localparam logic [15:0] SYNC_LAST  = 16'(SYNC_LEN - 1);
   localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_TMO - 1);
   localparam logic [15:0] ACK_LAST   = 16'(ACK_TMO - 1);
   localparam logic [3:0]  IDX_LAST   = 4'(N_REGS - 1);
   localparam logic [1:0]  RETRY_MAX  = 2'(MAX_RETRY);

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt, cnt_inc;
   logic        last_wr, last_wr_nxt;
   logic [3:0]  tbl_idx_nxt;
   logic        cfg_req_nxt, cfg_sel_nxt, adc_sync_nxt;
   logic [7:0]  cfg_addr_nxt;
   logic [15:0] cfg_data_nxt;
   logic        busy_nxt, done_nxt, fail_nxt;
   logic [1:0]  retry_cnt_nxt;
   logic [3:0]  al_s1, al_s2;
   logic        both_done, any_err;

   assign both_done = al_s2[3] & al_s2[2];
   assign any_err   = al_s2[1] | al_s2[0];
   assign cnt_inc   = (cnt == '1) ? cnt : cnt + 16'd1;
   assign state_dbg = state;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt_inc;
      last_wr_nxt   = last_wr;
      tbl_idx_nxt   = tbl_idx;
      cfg_req_nxt   = cfg_req;
      cfg_sel_nxt   = cfg_sel;
      cfg_addr_nxt  = cfg_addr;
      cfg_data_nxt  = cfg_data;
      adc_sync_nxt  = adc_sync;
      busy_nxt      = busy;
      done_nxt      = done;
      fail_nxt      = fail;
      retry_cnt_nxt = retry_cnt;
      case (state)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               state_nxt     = S_PWRUP;
               cnt_nxt       = '0;
               last_wr_nxt   = 1'b0;
               tbl_idx_nxt   = '0;
               cfg_sel_nxt   = 1'b0;
               done_nxt      = 1'b0;
               fail_nxt      = 1'b0;
               retry_cnt_nxt = '0;
               busy_nxt      = 1'b1;
            end
         end
         S_PWRUP: begin
            if (cnt >= PWRUP_LAST) begin
               state_nxt    = S_REQ;
               cnt_nxt      = '0;
               cfg_addr_nxt = tbl_data[23:16];
               cfg_data_nxt = tbl_data[15:0];
               cfg_req_nxt  = 1'b1;
            end
         end
         S_REQ: begin
            state_nxt = S_WACK;
            cnt_nxt   = '0;
         end
         S_WACK: begin
            if (cfg_ack) begin
               // Table position advances on the ack edge so the ROM word is
               // already valid while in NEXT and can be latched on REQ entry.
               state_nxt   = S_NEXT;
               cfg_req_nxt = 1'b0;
               if (tbl_idx < IDX_LAST) begin
                  tbl_idx_nxt = tbl_idx + 4'd1;
               end else if (!cfg_sel) begin
                  cfg_sel_nxt = 1'b1;
                  tbl_idx_nxt = '0;
               end else begin
                  last_wr_nxt = 1'b1;
               end
            end else if (cnt >= ACK_LAST) begin
               state_nxt    = S_FAIL;
               cfg_req_nxt  = 1'b0;
               adc_sync_nxt = 1'b0;
               busy_nxt     = 1'b0;
               fail_nxt     = 1'b1;
            end
         end
         S_NEXT: begin
            cnt_nxt = '0;
            if (last_wr) begin
               state_nxt    = S_SYNC;
               adc_sync_nxt = 1'b1;
            end else begin
               state_nxt    = S_REQ;
               cfg_addr_nxt = tbl_data[23:16];
               cfg_data_nxt = tbl_data[15:0];
               cfg_req_nxt  = 1'b1;
            end
         end
         S_SYNC: begin
            if (cnt >= SYNC_LAST) begin
               state_nxt    = S_ALIGN;
               cnt_nxt      = '0;
               adc_sync_nxt = 1'b0;
            end
         end
         S_ALIGN: begin
            if (any_err) begin
               state_nxt = S_RETRY;
            end else if (both_done) begin
               state_nxt = S_DONE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else if (cnt >= ALIGN_LAST) begin
               state_nxt = S_RETRY;
            end
         end
         S_RETRY: begin
            cnt_nxt = '0;
            if (retry_cnt < RETRY_MAX) begin
               state_nxt     = S_SYNC;
               retry_cnt_nxt = retry_cnt + 2'd1;
               adc_sync_nxt  = 1'b1;
            end else begin
               state_nxt    = S_FAIL;
               cfg_req_nxt  = 1'b0;
               adc_sync_nxt = 1'b0;
               busy_nxt     = 1'b0;
               fail_nxt     = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk10m or negedge sysrst_nr0) begin
      if (!sysrst_nr0) begin
         state     <= S_IDLE;
         cnt       <= '0;
         last_wr   <= 1'b0;
         tbl_idx   <= '0;
         cfg_req   <= 1'b0;
         cfg_sel   <= 1'b0;
         cfg_addr  <= '0;
         cfg_data  <= '0;
         adc_sync  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         retry_cnt <= '0;
         al_s1     <= '0;
         al_s2     <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last_wr   <= last_wr_nxt;
         tbl_idx   <= tbl_idx_nxt;
         cfg_req   <= cfg_req_nxt;
         cfg_sel   <= cfg_sel_nxt;
         cfg_addr  <= cfg_addr_nxt;
         cfg_data  <= cfg_data_nxt;
         adc_sync  <= adc_sync_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         fail      <= fail_nxt;
         retry_cnt <= retry_cnt_nxt;
         al_s1     <= {a_align_done, b_align_done, a_align_err, b_align_err};
         al_s2     <= al_s1;
      end
   end

endmodule
